// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared width default, divisor type and channel-index width helper.
package clk_div_pkg;
  localparam int DEF_DIV_W = 16;
  typedef logic [DEF_DIV_W-1:0] div_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a shadowed divisor that reloads only on period boundaries.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = 25000
) (
  input  logic             osc_clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_val,
  input  logic             sync,
  output logic             tick,
  output logic             clk_out,
  output logic             running
);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, sh_q, sh_d;
  logic tick_q, tick_d, clk_q, clk_d, run, wrap, restart;
  always_comb begin
    run     = act_q != '0;
    wrap    = run && cnt_q == act_q - 1'b1;
    restart = sync || wrap || !run;
    sh_d    = ld ? ld_val : sh_q;
    act_d   = restart ? sh_d : act_q;
    cnt_d   = restart ? '0 : cnt_q + 1'b1;
    tick_d  = wrap && !sync;
    // a zero divisor taking effect parks the square wave low
    clk_d   = (sync || act_d == '0) ? 1'b0 : wrap ? !clk_q : clk_q;
  end
  always_ff @(posedge osc_clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      sh_q   <= RST_DIV;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end
  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign running = run;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable divider producing ticks and 50% square waves.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int DIV_W       = DEF_DIV_W,
  parameter  int DEFAULT_DIV = 25000,
  localparam int CH_W        = ch_w(N_CH)
) (
  input  logic             osc_clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  running
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .osc_clk (osc_clk),
      .clr     (clr),
      .ld      (wr_en && wr_ch == CH_W'(g)),
      .ld_val  (wr_div),
      .sync    (sync),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .running (running[g])
    );
  end
endmodule
